rf_wb_seq: RTL and testbench
============================

RF_WB_SEQ -- requirements
Module: rf_wb_seq

Interface
REQ-001 Parameters: FIFO_DEPTH, default 2, writeback queue entries; REG_W, default 4, register index width; DATA_W, default 32, data width.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) forces the reset state immediately.
REQ-004 wb_valid  in  1  writeback request present.
REQ-005 wb_ready  out  1  queue can accept; transfer when wb_valid & wb_ready at a rising edge.
REQ-006 wb_reg  in  REG_W  target register; wb_data  in  DATA_W  write data.
REQ-007 wb_hl  in  1  1 = write high half [31:16], 0 = write low half [15:0]; ignored when wb_full=1.
REQ-008 wb_full  in  1  1 = full 32-bit write.
REQ-009 rd_req  in  1; rd_port1, rd_port2  in  REG_W  read port selects from decode.
REQ-010 rd_ack  out  1  register-file read outputs hold the rd_port1/rd_port2 values sampled in the previous cycle.
REQ-011 rf_we, rf_hl  out  1; rf_port1, rf_port2, rf_write_reg  out  REG_W; rf_data  out  DATA_W  register-file command port.
REQ-012 busy  out  1  queue non-empty or FSM not IDLE.

Function
REQ-013 The register file merges half-words using its third read output, which refreshes only in cycles with rf_we=0; this block SHALL guarantee at least one rf_we=0 cycle with rf_write_reg equal to the target immediately before every rf_we=1 cycle.
REQ-014 FSM states: IDLE, WR_A, PREP_B, WR_B; rf_we=1 only in WR_A and WR_B.
REQ-015 IDLE: rf_we=0; rf_write_reg = head entry reg if queue non-empty, else 0; next state WR_A if queue non-empty, else IDLE.
REQ-016 WR_A: rf_write_reg = head reg; rf_data = head data; rf_hl = 1 if head full, else head hl; half write -> pop, go IDLE; full write -> PREP_B.
REQ-017 PREP_B: rf_we=0, rf_write_reg = head reg; next WR_B.
REQ-018 WR_B: rf_hl=0, rf_data = head data, rf_write_reg = head reg; pop, go IDLE.
REQ-019 rf_port1/rf_port2 SHALL equal rd_port1/rd_port2 in every state.
REQ-020 rd_ack (registered) SHALL be 1 in cycle N+1 iff rd_req=1 and rf_we=0 in cycle N; the requester holds rd_req until rd_ack.
REQ-021 Throughput: one half write per 2 cycles, one full write per 4 cycles; first rf_we=1 occurs 2 cycles after the accepting edge if idle.
REQ-022 Queue: FIFO order; wb_ready = (count < FIFO_DEPTH); simultaneous push and pop keeps count; no push when full.
REQ-023 Back-to-back writes to the same register SHALL each be preceded by an IDLE cycle (REQ-013), so no merge uses stale data.
REQ-024 rf_data and rf_hl SHALL be 0 in rf_we=0 cycles.

Reset
REQ-025 On reset=0: state IDLE, queue empty, rf_we=0, rf_hl=0, rf_write_reg=0, rf_data=0, rd_ack=0, busy=0, wb_ready=1.
REQ-026 Reset during WR_A/PREP_B/WR_B SHALL abandon the in-flight entry without any further rf_we=1 cycle.

Structure
REQ-027 State encoding, REG_W, DATA_W and queue entry field layout {reg, data, hl, full} SHALL live in shared package rf_pkg.
REQ-028 The queue SHALL be a sub-module rf_wb_fifo (depth FIFO_DEPTH, count-based full/empty).

Verification
REQ-029 Bench SHALL include a behavioural register-file model with merge semantics identical to the real file, checked after each write.
REQ-030 Half write: reg 3 = 0x11112222; push reg 3, data 0xAAAA0000, hl=1 -> one rf_we=1 two cycles later, reg 3 = 0xAAAA2222.
REQ-031 Full write: push reg 5, data 0xDEADBEEF, full=1 -> rf_we pattern 0,1,0,1, rf_hl 1 then 0, reg 5 = 0xDEADBEEF.
REQ-032 Same-reg chain: reg 7 = 0; push (7, 0x12340000, hl=1) then (7, 0x00005678, hl=0) back-to-back -> reg 7 = 0x12345678, IDLE cycle between writes.
REQ-033 Backpressure: push 3 full writes with wb_valid held -> wb_ready=0 after 2 accepted, third accepted on first pop, all three committed in order.
REQ-034 Read stall: rd_req=1, rd_port1=2 during WR_A -> rd_ack=0 next cycle, rd_ack=1 after the following rf_we=0 cycle.
REQ-035 Reset mid-op: reset=0 in PREP_B of a full write -> no WR_B, outputs at REQ-025 values, queue empty.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg
// Shared definitions for the register-file writeback sequencer:
//   - default register index / data widths
//   - sequencer FSM state encoding
//   - writeback queue entry layout {reg, data, hl, full}
// No ports (package).
package rf_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_A   = 2'd1,
    ST_PREP_B = 2'd2,
    ST_WR_B   = 2'd3
  } wb_state_e;

  // One queued writeback request. 'hl' selects the high half when 'full' is 0.
  typedef struct packed {
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] data;
    logic              hl;
    logic              full;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_seq_if.sv
// rf_wb_seq_if
// Writeback request channel into the sequencer (valid/ready handshake).
//   wb_valid  request present          (master -> slave)
//   wb_ready  queue can accept         (slave  -> master)
//   wb_reg    target register index    (master -> slave)
//   wb_data   write data               (master -> slave)
//   wb_hl     1 = high half, 0 = low   (master -> slave)
//   wb_full   1 = full-width write     (master -> slave)
interface rf_wb_seq_if #(
  parameter int REG_W  = rf_pkg::REG_W,
  parameter int DATA_W = rf_pkg::DATA_W
);

  logic              wb_valid;
  logic              wb_ready;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_hl;
  logic              wb_full;

  modport master (
    output wb_valid, wb_reg, wb_data, wb_hl, wb_full,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_reg, wb_data, wb_hl, wb_full,
    output wb_ready
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo
// Small count-based FIFO holding pending writeback entries.
//   clk, reset   clock, asynchronous active-low reset
//   push         enqueue push_entry (ignored when full)
//   push_entry   entry to enqueue
//   pop          dequeue head (ignored when empty)
//   head         oldest entry (valid when !empty)
//   full, empty  occupancy flags derived from the entry count
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths also work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_seq.sv
// rf_wb_seq
// Sequences queued writebacks onto a half-word-merging register file.
// The file merges halves using a third read port that only refreshes in
// cycles with rf_we=0, so every write cycle is preceded by a non-write
// cycle that points rf_write_reg at the target. Full writes are split into
// a high-half write and a low-half write with a refresh cycle between them.
//   clk, reset            clock, asynchronous active-low reset
//   wb                    writeback request channel (slave side)
//   rd_req                decode wants register reads this cycle
//   rd_port1, rd_port2    read selects, passed straight through
//   rd_ack                previous cycle's read was not blocked by a write
//   rf_we, rf_hl          register-file write enable / half select
//   rf_port1, rf_port2    register-file read selects
//   rf_write_reg, rf_data register-file write target / data
//   busy                  queue non-empty or a write in progress
module rf_wb_seq #(
  parameter int FIFO_DEPTH = 2,
  parameter int REG_W      = rf_pkg::REG_W,
  parameter int DATA_W     = rf_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  rf_wb_seq_if.slave        wb,
  input  logic              rd_req,
  input  logic [REG_W-1:0]  rd_port1,
  input  logic [REG_W-1:0]  rd_port2,
  output logic              rd_ack,
  output logic              rf_we,
  output logic              rf_hl,
  output logic [REG_W-1:0]  rf_port1,
  output logic [REG_W-1:0]  rf_port2,
  output logic [REG_W-1:0]  rf_write_reg,
  output logic [DATA_W-1:0] rf_data,
  output logic              busy
);

  import rf_pkg::*;

  wb_state_e state_q;
  wb_state_e state_d;
  wb_entry_t push_entry;
  wb_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      push;
  logic      pop;

  assign wb.wb_ready = !fifo_full;
  assign push        = wb.wb_valid && wb.wb_ready;

  always_comb begin
    push_entry         = '0;
    push_entry.reg_idx = wb.wb_reg;
    push_entry.data    = wb.wb_data;
    push_entry.hl      = wb.wb_hl;
    push_entry.full    = wb.wb_full;
  end

  rf_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rf_port1 = rd_port1;
  assign rf_port2 = rd_port2;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every path back to a write passes through IDLE or PREP_B, which keeps
  // rf_we low while rf_write_reg already names the target, so the merge
  // port always holds the current contents of the register being written.
  always_comb begin
    state_d      = state_q;
    rf_we        = 1'b0;
    rf_hl        = 1'b0;
    rf_data      = '0;
    rf_write_reg = '0;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          rf_write_reg = head.reg_idx;
          state_d      = ST_WR_A;
        end
      end
      ST_WR_A: begin
        rf_we        = 1'b1;
        rf_write_reg = head.reg_idx;
        rf_data      = head.data;
        rf_hl        = head.full ? 1'b1 : head.hl;
        if (head.full) begin
          state_d = ST_PREP_B;
        end else begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_PREP_B: begin
        rf_write_reg = head.reg_idx;
        state_d      = ST_WR_B;
      end
      ST_WR_B: begin
        rf_we        = 1'b1;
        rf_write_reg = head.reg_idx;
        rf_data      = head.data;
        pop          = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A read is only serviced in a cycle where the file is not writing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ack <= 1'b0;
    end else begin
      rd_ack <= rd_req && !rf_we;
    end
  end

endmodule

// File: tb/tb_rf_wb_seq.sv
// tb_rf_wb_seq
// Self-checking bench for rf_wb_seq: a behavioural merging register file
// driven by the DUT command port, an architectural scoreboard filled on
// every accepted request, a table of single-write vectors and hand-written
// multi-cycle sequences.
module tb_rf_wb_seq;

  import rf_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_req;
  logic [REG_W-1:0]  rd_port1;
  logic [REG_W-1:0]  rd_port2;
  logic              rd_ack;
  logic              rf_we;
  logic              rf_hl;
  logic [REG_W-1:0]  rf_port1;
  logic [REG_W-1:0]  rf_port2;
  logic [REG_W-1:0]  rf_write_reg;
  logic [DATA_W-1:0] rf_data;
  logic              busy;

  rf_wb_seq_if #(.REG_W(REG_W), .DATA_W(DATA_W)) wb ();

  rf_wb_seq #(
    .FIFO_DEPTH(2),
    .REG_W     (REG_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (wb),
    .rd_req      (rd_req),
    .rd_port1    (rd_port1),
    .rd_port2    (rd_port2),
    .rd_ack      (rd_ack),
    .rf_we       (rf_we),
    .rf_hl       (rf_hl),
    .rf_port1    (rf_port1),
    .rf_port2    (rf_port2),
    .rf_write_reg(rf_write_reg),
    .rf_data     (rf_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r;
    logic        full;
    logic [31:0] value;
  } sb_t;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
    logic        hl;
    logic        full;
    logic [31:0] init;
    logic [31:0] expv;
  } vec_t;

  logic [31:0] regs [16];
  logic [31:0] arch [16];
  logic [31:0] third;
  sb_t         sb [$];
  int          progress;
  int          weTotal;
  int          backToBack;
  logic        prevWe;
  logic [3:0]  prevReg;
  int          checks;
  int          errors;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Register-file model plus scoreboard, evaluated once per cycle mid-cycle.
  task automatic modelStep();
    logic [31:0] merged;
    logic [31:0] newv;
    sb_t         e;
    if (!reset) begin
      sb.delete();
      progress = 0;
      prevWe   = 1'b0;
      prevReg  = '0;
      for (int i = 0; i < 16; i++) arch[i] = regs[i];
    end else begin
      if (rf_we) begin
        weTotal++;
        if (prevWe) backToBack++;
        checkOutput("refresh_cycle_before_write", {31'b0, prevWe}, 32'd0);
        checkOutput("refresh_target_before_write", {28'b0, prevReg}, {28'b0, rf_write_reg});
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got write to reg %0d, expected none", rf_write_reg);
        end else begin
          checkOutput("write_order", {28'b0, rf_write_reg}, {28'b0, sb[0].r});
          merged = rf_hl ? {rf_data[31:16], third[15:0]} : {third[31:16], rf_data[15:0]};
          regs[rf_write_reg] = merged;
          progress++;
          if (progress == (sb[0].full ? 2 : 1)) begin
            checkOutput("commit_value", regs[sb[0].r], sb[0].value);
            void'(sb.pop_front());
            progress = 0;
          end
        end
      end else begin
        third = regs[rf_write_reg];
        checkOutput("idle_data_zero", rf_data, 32'd0);
        checkOutput("idle_hl_zero", {31'b0, rf_hl}, 32'd0);
      end
      prevWe  = rf_we;
      prevReg = rf_write_reg;
      if (wb.wb_valid && wb.wb_ready) begin
        if (wb.wb_full) newv = wb.wb_data;
        else if (wb.wb_hl) newv = {wb.wb_data[31:16], arch[wb.wb_reg][15:0]};
        else newv = {arch[wb.wb_reg][31:16], wb.wb_data[15:0]};
        arch[wb.wb_reg] = newv;
        e.r     = wb.wb_reg;
        e.full  = wb.wb_full;
        e.value = newv;
        sb.push_back(e);
      end
    end
  endtask

  task automatic toNegedge();
    @(negedge clk);
    modelStep();
  endtask

  task automatic toNext();
    @(posedge clk);
    #1;
  endtask

  task automatic cycleStep();
    toNegedge();
    toNext();
  endtask

  // Holds the request until accepted; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d,
                               input logic hl, input logic full, output int waits);
    logic accepted;
    accepted    = 1'b0;
    waits       = 0;
    wb.wb_reg   = r;
    wb.wb_data  = d;
    wb.wb_hl    = hl;
    wb.wb_full  = full;
    wb.wb_valid = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      toNegedge();
      accepted = wb.wb_ready;
      toNext();
      if (!accepted) waits++;
    end
    wb.wb_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept for reg %0d, expected accept", r);
    end
  endtask

  task automatic waitIdle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      toNegedge();
      done = !busy && (sb.size() == 0);
      toNext();
    end
    checkOutput({name, "_drain"}, {31'b0, done}, 32'd1);
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_rf_we"}, {31'b0, rf_we}, 32'd0);
    checkOutput({name, "_rf_hl"}, {31'b0, rf_hl}, 32'd0);
    checkOutput({name, "_rf_write_reg"}, {28'b0, rf_write_reg}, 32'd0);
    checkOutput({name, "_rf_data"}, rf_data, 32'd0);
    checkOutput({name, "_rd_ack"}, {31'b0, rd_ack}, 32'd0);
    checkOutput({name, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({name, "_wb_ready"}, {31'b0, wb.wb_ready}, 32'd1);
  endtask

  initial begin
    vec_t        vecs [6];
    int          w;
    int          we0;
    int          b0;
    logic [3:0]  weExp;
    logic [3:0]  hlExp;

    checks     = 0;
    errors     = 0;
    progress   = 0;
    weTotal    = 0;
    backToBack = 0;
    prevWe     = 1'b0;
    prevReg    = '0;
    third      = '0;
    for (int i = 0; i < 16; i++) begin
      regs[i] = '0;
      arch[i] = '0;
    end

    reset       = 1'b0;
    rd_req      = 1'b0;
    rd_port1    = '0;
    rd_port2    = '0;
    wb.wb_valid = 1'b0;
    wb.wb_reg   = '0;
    wb.wb_data  = '0;
    wb.wb_hl    = 1'b0;
    wb.wb_full  = 1'b0;

    #2;
    checkReset("por");
    #10;
    reset = 1'b1;
    toNext();

    vecs[0] = '{4'd1,  32'h0000BBBB, 1'b0, 1'b0, 32'h11112222, 32'h1111BBBB};
    vecs[1] = '{4'd4,  32'hAAAA0000, 1'b1, 1'b0, 32'h11112222, 32'hAAAA2222};
    vecs[2] = '{4'd6,  32'hDEADBEEF, 1'b0, 1'b1, 32'h00000000, 32'hDEADBEEF};
    vecs[3] = '{4'd15, 32'h12345678, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h12345678};
    vecs[4] = '{4'd0,  32'h5555AAAA, 1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEAAAA};
    vecs[5] = '{4'd9,  32'h0F0F0F0F, 1'b1, 1'b1, 32'h76543210, 32'h0F0F0F0F};

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].r, vecs[i].init, 1'b0, 1'b1, w);
      applyStimulus(vecs[i].r, vecs[i].d, vecs[i].hl, vecs[i].full, w);
      waitIdle($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_reg", i), regs[vecs[i].r], vecs[i].expv);
    end

    // Half write timing: refresh cycle, one write, back to idle.
    applyStimulus(4'd3, 32'h11112222, 1'b0, 1'b1, w);
    waitIdle("half_preload");
    applyStimulus(4'd3, 32'hAAAA0000, 1'b1, 1'b0, w);
    toNegedge();
    checkOutput("half_c1_we", {31'b0, rf_we}, 32'd0);
    checkOutput("half_c1_target", {28'b0, rf_write_reg}, 32'd3);
    toNext();
    toNegedge();
    checkOutput("half_c2_we", {31'b0, rf_we}, 32'd1);
    checkOutput("half_c2_hl", {31'b0, rf_hl}, 32'd1);
    toNext();
    toNegedge();
    checkOutput("half_c3_we", {31'b0, rf_we}, 32'd0);
    toNext();
    waitIdle("half");
    checkOutput("half_reg3", regs[3], 32'hAAAA2222);

    // Full write: write enable 0,1,0,1 with high half first.
    weExp = 4'b1010;
    hlExp = 4'b0010;
    applyStimulus(4'd5, 32'hDEADBEEF, 1'b0, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      toNegedge();
      checkOutput($sformatf("full_c%0d_we", i), {31'b0, rf_we}, {31'b0, weExp[i]});
      checkOutput($sformatf("full_c%0d_hl", i), {31'b0, rf_hl}, {31'b0, hlExp[i]});
      toNext();
    end
    waitIdle("full");
    checkOutput("full_reg5", regs[5], 32'hDEADBEEF);

    // Same-register chain: two halves back to back must not merge stale data.
    applyStimulus(4'd7, 32'h00000000, 1'b0, 1'b1, w);
    waitIdle("chain_preload");
    we0 = weTotal;
    b0  = backToBack;
    applyStimulus(4'd7, 32'h12340000, 1'b1, 1'b0, w);
    applyStimulus(4'd7, 32'h00005678, 1'b0, 1'b0, w);
    waitIdle("chain");
    checkOutput("chain_reg7", regs[7], 32'h12345678);
    checkOutput("chain_write_count", weTotal - we0, 32'd2);
    checkOutput("chain_adjacent_writes", backToBack - b0, 32'd0);

    // Backpressure: third full write waits for the first pop.
    applyStimulus(4'd10, 32'hA0A0A0A0, 1'b0, 1'b1, w);
    checkOutput("bp_first_waits", w, 32'd0);
    applyStimulus(4'd11, 32'hB1B1B1B1, 1'b0, 1'b1, w);
    checkOutput("bp_second_waits", w, 32'd0);
    wb.wb_reg   = 4'd12;
    wb.wb_data  = 32'hC2C2C2C2;
    wb.wb_hl    = 1'b0;
    wb.wb_full  = 1'b1;
    wb.wb_valid = 1'b1;
    toNegedge();
    checkOutput("bp_ready_low", {31'b0, wb.wb_ready}, 32'd0);
    toNext();
    applyStimulus(4'd12, 32'hC2C2C2C2, 1'b0, 1'b1, w);
    checkOutput("bp_third_waits", w, 32'd2);
    waitIdle("bp");
    checkOutput("bp_reg10", regs[10], 32'hA0A0A0A0);
    checkOutput("bp_reg11", regs[11], 32'hB1B1B1B1);
    checkOutput("bp_reg12", regs[12], 32'hC2C2C2C2);

    // Read stall: request during a write cycle is acked only after a free cycle.
    applyStimulus(4'd2, 32'h00002222, 1'b0, 1'b0, w);
    cycleStep();
    rd_req   = 1'b1;
    rd_port1 = 4'd2;
    rd_port2 = 4'd9;
    toNegedge();
    checkOutput("rd_c2_we", {31'b0, rf_we}, 32'd1);
    checkOutput("rd_port1_pass", {28'b0, rf_port1}, 32'd2);
    checkOutput("rd_port2_pass", {28'b0, rf_port2}, 32'd9);
    toNext();
    toNegedge();
    checkOutput("rd_c3_ack", {31'b0, rd_ack}, 32'd0);
    checkOutput("rd_c3_we", {31'b0, rf_we}, 32'd0);
    toNext();
    toNegedge();
    checkOutput("rd_c4_ack", {31'b0, rd_ack}, 32'd1);
    toNext();
    rd_req = 1'b0;
    cycleStep();
    toNegedge();
    checkOutput("rd_c6_ack", {31'b0, rd_ack}, 32'd0);
    toNext();
    waitIdle("rd");
    checkOutput("rd_reg2", regs[2], 32'h00002222);

    // Reset in PREP_B abandons the second half of a full write.
    applyStimulus(4'd13, 32'hAAAAAAAA, 1'b0, 1'b1, w);
    waitIdle("rst_preload");
    applyStimulus(4'd13, 32'h13571357, 1'b0, 1'b1, w);
    cycleStep();
    cycleStep();
    checkOutput("rst_prep_we", {31'b0, rf_we}, 32'd0);
    checkOutput("rst_prep_target", {28'b0, rf_write_reg}, 32'd13);
    reset = 1'b0;
    #1;
    checkReset("mid_reset");
    cycleStep();
    cycleStep();
    reset = 1'b1;
    we0 = weTotal;
    for (int i = 0; i < 6; i++) cycleStep();
    checkOutput("rst_no_more_writes", weTotal - we0, 32'd0);
    checkOutput("rst_busy_after", {31'b0, busy}, 32'd0);
    checkOutput("rst_ready_after", {31'b0, wb.wb_ready}, 32'd1);
    checkOutput("rst_reg13_partial", regs[13], 32'h1357AAAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
